urv_trap_ctrl: RTL and testbench

Machine-mode trap controller for the uRV core: holds MSTATUS, MIE, MIP, MEPC and MCAUSE, and decides when the execute stage takes an exception, an interrupt or an MRET. It receives the CSR write value and select from the CSR unit and drives the `csr_*` register values back to it for CSR reads. It also drives a PC redirect to fetch.

---
 rtl/urv_trap_ctrl.sv | 149 ++++++++++++++
 tb/tb_urv_trap_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/urv_trap_ctrl.sv
// urv_trap_ctrl: machine-mode trap controller for the uRV core.
// Holds MSTATUS/MIE/MIP/MEPC/MCAUSE and arbitrates exceptions, interrupts
// and MRET for the instruction in execute. It also drives the fetch redirect.
module urv_trap_ctrl #(
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0008
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        x_valid_i,
  input  logic [31:0] x_pc_i,
  input  logic        x_is_csr_i,
  input  logic [11:0] x_csr_sel_i,
  input  logic [31:0] x_csr_write_value_i,
  input  logic        x_exception_i,
  input  logic [3:0]  x_exception_cause_i,
  input  logic        x_is_mret_i,
  input  logic        irq_ext_i,
  input  logic        irq_timer_i,
  output logic        x_redirect_o,
  output logic [31:0] x_redirect_pc_o,
  output logic [31:0] csr_mstatus_o,
  output logic [31:0] csr_mip_o,
  output logic [31:0] csr_mie_o,
  output logic [31:0] csr_mepc_o,
  output logic [31:0] csr_mcause_o
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]  state;
  logic        mstatus_mie, mstatus_mpie;
  logic        mie_meie, mie_mtie;
  logic [1:0]  meip_sync;
  logic [29:0] mepc_q;
  logic        mcause_irq;
  logic [3:0]  mcause_code;

  logic        mip_meip, mip_mtip;
  logic        take_exc, take_ext, take_tmr, take_mret, take_trap;
  logic        trap_irq;
  logic [3:0]  trap_code;
  logic        csr_we;
  logic [31:0] wv;

  assign mip_meip = meip_sync[1];
  assign mip_mtip = irq_timer_i;
  assign wv       = x_csr_write_value_i;

  // Event arbitration: exception > external irq > timer irq > MRET, only in RUN.
  always_comb begin
    take_exc  = 1'b0;
    take_ext  = 1'b0;
    take_tmr  = 1'b0;
    take_mret = 1'b0;
    if (x_valid_i && state == ST_RUN) begin
      if (x_exception_i)                             take_exc  = 1'b1;
      else if (mstatus_mie && mie_meie && mip_meip)  take_ext  = 1'b1;
      else if (mstatus_mie && mie_mtie && mip_mtip)  take_tmr  = 1'b1;
      else if (x_is_mret_i)                          take_mret = 1'b1;
    end
  end

  assign take_trap = take_exc | take_ext | take_tmr;
  assign trap_irq  = take_ext | take_tmr;

  // Cause code of whichever trap won arbitration.
  always_comb begin
    trap_code = 4'd0;
    if (take_exc)      trap_code = x_exception_cause_i;
    else if (take_ext) trap_code = 4'd11;
    else if (take_tmr) trap_code = 4'd7;
  end

  // Redirect target; zero when idle so the bus is deterministic.
  always_comb begin
    x_redirect_o    = take_trap | take_mret;
    x_redirect_pc_o = 32'h0;
    if (take_trap)      x_redirect_pc_o = TRAP_VECTOR;
    else if (take_mret) x_redirect_pc_o = {mepc_q, 2'b00};
  end

  // A taken trap/MRET swallows the CSR write of the same instruction.
  assign csr_we = x_valid_i && x_is_csr_i && !x_redirect_o;

  // Two-flop synchroniser for the asynchronous external interrupt.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) meip_sync <= 2'b00;
    else          meip_sync <= {meip_sync[0], irq_ext_i};
  end

  // One dead cycle after every redirect so the stale instruction cannot re-trap.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)          state <= ST_RUN;
    else if (x_redirect_o) state <= ST_FLUSH;
    else                   state <= ST_RUN;
  end

  // Architectural CSR state: trap/MRET side effects or software writes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_meie     <= 1'b0;
      mie_mtie     <= 1'b0;
      mepc_q       <= 30'h0;
      mcause_irq   <= 1'b0;
      mcause_code  <= 4'h0;
    end else if (take_trap) begin
      mepc_q       <= x_pc_i[31:2];
      mcause_irq   <= trap_irq;
      mcause_code  <= trap_code;
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (take_mret) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (csr_we) begin
      case (x_csr_sel_i)
        CSR_MSTATUS: begin
          mstatus_mie  <= wv[3];
          mstatus_mpie <= wv[7];
        end
        CSR_MIE: begin
          mie_meie <= wv[11];
          mie_mtie <= wv[7];
        end
        CSR_MEPC:   mepc_q <= wv[31:2];
        CSR_MCAUSE: begin
          mcause_irq  <= wv[31];
          mcause_code <= wv[3:0];
        end
        default: ;
      endcase
    end
  end

  assign csr_mstatus_o = {24'h0, mstatus_mpie, 3'b000, mstatus_mie, 3'b000};
  assign csr_mie_o     = {20'h0, mie_meie, 3'b000, mie_mtie, 7'h00};
  assign csr_mip_o     = {20'h0, mip_meip, 3'b000, mip_mtip, 7'h00};
  assign csr_mepc_o    = {mepc_q, 2'b00};
  assign csr_mcause_o  = {mcause_irq, 27'h0, mcause_code};

endmodule

// File: tb/tb_urv_trap_ctrl.sv
// tb_urv_trap_ctrl: directed + random stimulus, scoreboard against a CSR-level model.
`timescale 1ns/1ps
module tb_urv_trap_ctrl;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        csr;
    logic [11:0] sel;
    logic [31:0] wv;
    logic        exc;
    logic [3:0]  cause;
    logic        mret;
    logic        ext;
    logic        tmr;
  } stim_t;

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] mstatus, mip, mie, mepc, mcause;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        x_valid_i = 1'b0;
  logic [31:0] x_pc_i = '0;
  logic        x_is_csr_i = 1'b0;
  logic [11:0] x_csr_sel_i = '0;
  logic [31:0] x_csr_write_value_i = '0;
  logic        x_exception_i = 1'b0;
  logic [3:0]  x_exception_cause_i = '0;
  logic        x_is_mret_i = 1'b0;
  logic        irq_ext_i = 1'b0;
  logic        irq_timer_i = 1'b0;
  logic        x_redirect_o;
  logic [31:0] x_redirect_pc_o;
  logic [31:0] csr_mstatus_o, csr_mip_o, csr_mie_o, csr_mepc_o, csr_mcause_o;

  urv_trap_ctrl #(.TRAP_VECTOR(32'h0000_0008)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .x_valid_i(x_valid_i), .x_pc_i(x_pc_i), .x_is_csr_i(x_is_csr_i),
    .x_csr_sel_i(x_csr_sel_i), .x_csr_write_value_i(x_csr_write_value_i),
    .x_exception_i(x_exception_i), .x_exception_cause_i(x_exception_cause_i),
    .x_is_mret_i(x_is_mret_i), .irq_ext_i(irq_ext_i), .irq_timer_i(irq_timer_i),
    .x_redirect_o(x_redirect_o), .x_redirect_pc_o(x_redirect_pc_o),
    .csr_mstatus_o(csr_mstatus_o), .csr_mip_o(csr_mip_o), .csr_mie_o(csr_mie_o),
    .csr_mepc_o(csr_mepc_o), .csr_mcause_o(csr_mcause_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int passes = 0;
  exp_t sb_q[$];

  // reference model state: architectural CSR values
  logic [31:0] m_mstatus, m_mie, m_mepc, m_mcause;
  logic        m_flush;
  logic        ext_d1, ext_d2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_mstatus = 0; m_mie = 0; m_mepc = 0; m_mcause = 0;
    m_flush = 0; ext_d1 = 0; ext_d2 = 0;
  endtask

  function automatic stim_t idle_s();
    stim_t s;
    s.v = 0; s.pc = 0; s.csr = 0; s.sel = 0; s.wv = 0; s.exc = 0;
    s.cause = 0; s.mret = 0; s.ext = 0; s.tmr = 0;
    return s;
  endfunction

  function automatic stim_t wr_s(input logic [11:0] sel, input logic [31:0] wv);
    stim_t s = idle_s();
    s.v = 1; s.csr = 1; s.sel = sel; s.wv = wv; s.pc = 32'h40;
    return s;
  endfunction

  // Drive one instruction slot; predict this cycle's outputs and next state.
  task automatic cyc(input stim_t s);
    exp_t e;
    logic trap;
    logic [31:0] cause, mip;
    @(posedge clk_i);
    #1;
    x_valid_i = s.v; x_pc_i = s.pc; x_is_csr_i = s.csr; x_csr_sel_i = s.sel;
    x_csr_write_value_i = s.wv; x_exception_i = s.exc; x_exception_cause_i = s.cause;
    x_is_mret_i = s.mret; irq_ext_i = s.ext; irq_timer_i = s.tmr;
    mip = (ext_d2 ? 32'h800 : 32'h0) | (s.tmr ? 32'h80 : 32'h0);
    e.mstatus = m_mstatus; e.mip = mip; e.mie = m_mie; e.mepc = m_mepc; e.mcause = m_mcause;
    e.redir = 0; e.rpc = 0; trap = 0; cause = 0;
    if (!m_flush && s.v) begin
      if (s.exc) begin trap = 1; cause = {28'h0, s.cause}; end
      else if (m_mstatus[3] && (m_mie & mip & 32'h800) != 0) begin trap = 1; cause = 32'h8000_000B; end
      else if (m_mstatus[3] && (m_mie & mip & 32'h80) != 0) begin trap = 1; cause = 32'h8000_0007; end
      else if (s.mret) begin e.redir = 1; e.rpc = m_mepc; end
    end
    if (trap) begin e.redir = 1; e.rpc = 32'h8; end
    sb_q.push_back(e);
    if (trap) begin
      m_mepc = s.pc & ~32'h3;
      m_mcause = cause;
      m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
    end else if (e.redir) begin
      m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
    end else if (s.v && s.csr) begin
      case (s.sel)
        12'h300: m_mstatus = s.wv & 32'h88;
        12'h304: m_mie     = s.wv & 32'h880;
        12'h341: m_mepc    = s.wv & ~32'h3;
        12'h342: m_mcause  = s.wv & 32'h8000_000F;
        default: ;
      endcase
    end
    m_flush = e.redir;
    ext_d2 = ext_d1;
    ext_d1 = s.ext;
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    @(posedge clk_i);
    #3;
    x_valid_i = 0; x_is_csr_i = 0; x_exception_i = 0; x_is_mret_i = 0;
    irq_ext_i = 0; irq_timer_i = 0;
    rst_n_i = 0;
    #1;
    chk("rst_mstatus", csr_mstatus_o, 32'h0);
    chk("rst_mie", csr_mie_o, 32'h0);
    chk("rst_mip", csr_mip_o, 32'h0);
    chk("rst_mepc", csr_mepc_o, 32'h0);
    chk("rst_mcause", csr_mcause_o, 32'h0);
    chk("rst_redir", {31'h0, x_redirect_o}, 32'h0);
    chk("rst_rpc", x_redirect_pc_o, 32'h0);
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1;
  endtask

  // Monitor: one expectation per driven slot, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sb_redir", {31'h0, x_redirect_o}, {31'h0, e.redir});
        chk("sb_rpc", x_redirect_pc_o, e.rpc);
        chk("sb_mstatus", csr_mstatus_o, e.mstatus);
        chk("sb_mip", csr_mip_o, e.mip);
        chk("sb_mie", csr_mie_o, e.mie);
        chk("sb_mepc", csr_mepc_o, e.mepc);
        chk("sb_mcause", csr_mcause_o, e.mcause);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    logic ext_l, tmr_l;
    logic [11:0] sels [6];
    sels[0] = 12'h300; sels[1] = 12'h304; sels[2] = 12'h341;
    sels[3] = 12'h342; sels[4] = 12'h344; sels[5] = 12'h7C0;
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1;

    // write masking
    cyc(wr_s(12'h304, 32'hFFFF_FFFF));
    cyc(wr_s(12'h341, 32'hFFFF_FFFF)); chk("mask_mie", csr_mie_o, 32'h880);
    cyc(wr_s(12'h342, 32'hFFFF_FFFF)); chk("mask_mepc", csr_mepc_o, 32'hFFFF_FFFC);
    cyc(wr_s(12'h344, 32'hFFFF_FFFF)); chk("mask_mcause", csr_mcause_o, 32'h8000_000F);
    cyc(wr_s(12'h300, 32'hFFFF_FFFF)); chk("mask_mip", csr_mip_o, 32'h0);
    cyc(wr_s(12'h300, 32'h8));         chk("mask_mstatus", csr_mstatus_o, 32'h88);

    // exception, then FLUSH with exception still held
    s = idle_s(); s.v = 1; s.pc = 32'h100; s.exc = 1; s.cause = 4'd2;
    cyc(s);
    chk("exc_redir", {31'h0, x_redirect_o}, 32'h1);
    chk("exc_rpc", x_redirect_pc_o, 32'h8);
    cyc(s);
    chk("flush_redir", {31'h0, x_redirect_o}, 32'h0);
    chk("exc_mepc", csr_mepc_o, 32'h100);
    chk("exc_mcause", csr_mcause_o, 32'h2);
    chk("exc_mstatus", csr_mstatus_o, 32'h80);

    // take another trap and reset in its FLUSH cycle; RUN must be back
    cyc(s);
    do_reset();
    cyc(s);
    chk("post_rst_redir", {31'h0, x_redirect_o}, 32'h1);
    cyc(idle_s());

    // external interrupt beats timer, 2 edges of synchroniser latency
    cyc(wr_s(12'h304, 32'h880));
    cyc(wr_s(12'h300, 32'h8));
    s = idle_s(); s.ext = 1; s.tmr = 1;
    cyc(s);
    cyc(s);
    chk("meip_late", csr_mip_o, 32'h80);
    s.v = 1; s.pc = 32'h200;
    cyc(s);
    chk("ext_redir", {31'h0, x_redirect_o}, 32'h1);
    s.v = 0;
    cyc(s);
    chk("ext_mcause", csr_mcause_o, 32'h8000_000B);
    chk("ext_mepc", csr_mepc_o, 32'h200);
    s = wr_s(12'h300, 32'h8); s.ext = 1; s.tmr = 1;
    cyc(s);
    chk("en_same_instr", {31'h0, x_redirect_o}, 32'h0);
    s = idle_s(); s.ext = 1; s.tmr = 1; s.v = 1; s.pc = 32'h300; s.exc = 1; s.cause = 4'd5;
    cyc(s);
    s.v = 0; s.exc = 0;
    cyc(s);
    chk("exc_wins", csr_mcause_o, 32'h5);

    // MRET uses the MEPC written the cycle before
    cyc(wr_s(12'h300, 32'h80));
    cyc(wr_s(12'h341, 32'h204));
    s = idle_s(); s.v = 1; s.mret = 1; s.pc = 32'h50;
    cyc(s);
    chk("mret_rpc", x_redirect_pc_o, 32'h204);
    cyc(idle_s());
    chk("mret_mstatus", csr_mstatus_o, 32'h88);

    // timer trap collides with a CSR write: write dropped
    cyc(wr_s(12'h304, 32'h80));
    cyc(wr_s(12'h300, 32'h8));
    s = wr_s(12'h300, 32'h0); s.tmr = 1;
    cyc(s);
    cyc(idle_s());
    chk("coll_mstatus", csr_mstatus_o, 32'h80);
    chk("coll_mcause", csr_mcause_o, 32'h8000_0007);

    // random phase
    ext_l = 0; tmr_l = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) ext_l = ~ext_l;
      if ($urandom_range(15) == 0) tmr_l = ~tmr_l;
      s = idle_s();
      s.v     = ($urandom_range(9) < 8);
      s.pc    = $urandom & ~32'h3;
      s.csr   = ($urandom_range(9) < 4);
      s.sel   = sels[$urandom_range(5)];
      s.wv    = $urandom;
      s.exc   = ($urandom_range(9) == 0);
      s.cause = 4'($urandom_range(15));
      s.mret  = ($urandom_range(9) == 0);
      s.ext   = ext_l;
      s.tmr   = tmr_l;
      cyc(s);
      if (i == 1500) do_reset();
    end
    cyc(idle_s());
    repeat (2) @(posedge clk_i);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
